// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage of the pipelined RISC-V core.
package rv_fetch_pkg;

    typedef logic [63:0] pc_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        pc_t         pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold keeps contents, bubble loads a NOP tagged with bubble_pc.
module if_id_reg
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   load_bubble,
    input  pc_t    bubble_pc,
    input  if_id_t d,
    output if_id_t q
);

    // Reset has top priority, then hold, then bubble, then a normal capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q.pc    <= '0;
            q.instr <= BUBBLE_INSTR;
            q.valid <= 1'b0;
        end else if (hold) begin
            q <= q;
        end else if (load_bubble) begin
            q.pc    <= bubble_pc;
            q.instr <= BUBBLE_INSTR;
            q.valid <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC register and BOOT/RUN/HALT sequencing for instruction fetch; feeds the IF/ID register.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_BYTES = 132,
    parameter logic [31:0] NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] Instruction,
    output logic [63:0] Inst_Address,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fault
);

    import rv_fetch_pkg::pc_t;
    import rv_fetch_pkg::if_id_t;
    import rv_fetch_pkg::fetch_state_e;
    import rv_fetch_pkg::ST_BOOT;
    import rv_fetch_pkg::ST_RUN;
    import rv_fetch_pkg::ST_HALT;

    localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

    fetch_state_e state_q, state_d;
    pc_t          pc_q, pc_d;
    logic         halted_q, halted_d;
    logic         fault_q, fault_d;
    logic         ifid_hold, ifid_bubble;
    logic         pc_in_range;
    if_id_t       ifid_d, ifid_q;

    // 65-bit sum so a PC near 2^64 cannot wrap back into the legal window.
    assign pc_in_range = ({1'b0, pc_q} + 65'd3) < MEM_LIMIT;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        halted_d    = halted_q;
        fault_d     = fault_q;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (pc_in_range) begin
                    ifid_hold = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    ifid_bubble = 1'b1;
                    halted_d    = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_RUN: begin
                if (branch_taken) begin
                    ifid_bubble = 1'b1;
                    if (branch_target[1:0] != 2'b00) begin
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d = branch_target;
                    end
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (!pc_in_range) begin
                    ifid_bubble = 1'b1;
                    halted_d    = 1'b1;
                    state_d     = ST_HALT;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                    pc_d        = pc_q + 64'd4;
                end else begin
                    pc_d = pc_q + 64'd4;
                end
            end
            ST_HALT: begin
                ifid_hold = 1'b1;
            end
            default: begin
                ifid_bubble = 1'b1;
                halted_d    = 1'b1;
                state_d     = ST_HALT;
            end
        endcase
    end

    always_comb begin
        ifid_d.pc    = pc_q;
        ifid_d.instr = Instruction;
        ifid_d.valid = 1'b1;
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .hold       (ifid_hold),
        .load_bubble(ifid_bubble),
        .bubble_pc  (pc_q),
        .d          (ifid_d),
        .q          (ifid_q)
    );

    assign Inst_Address = pc_q;
    assign if_id_pc     = ifid_q.pc;
    assign if_id_instr  = ifid_q.instr;
    assign if_id_valid  = ifid_q.valid;
    assign halted       = halted_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 132-byte little-endian instruction memory model.
module tb_fetch_sequencer;

    localparam int MEM_BYTES = 132;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        fault;

    logic [7:0] mem [0:MEM_BYTES-1];

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .RESET_PC (64'd0),
        .MEM_BYTES(MEM_BYTES),
        .NOP_INSTR(32'h00000013)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .Instruction  (Instruction),
        .Inst_Address (Inst_Address),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fault        (fault)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational memory model; out-of-range reads return zero
    always_comb begin
        Instruction = 32'h0;
        if (Inst_Address < 64'(MEM_BYTES - 3)) begin
            Instruction = {mem[int'(Inst_Address) + 3], mem[int'(Inst_Address) + 2],
                           mem[int'(Inst_Address) + 1], mem[int'(Inst_Address)]};
        end
    end

    task automatic put_word(input int addr, input logic [31:0] w);
        mem[addr]     = w[7:0];
        mem[addr + 1] = w[15:8];
        mem[addr + 2] = w[23:16];
        mem[addr + 3] = w[31:24];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        checks++;
        if ({Inst_Address, if_id_pc, if_id_instr, if_id_valid, halted, fault} !==
            {64'h0, 64'h0, 32'h00000013, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: addr=%h pc=%h instr=%h v=%b h=%b f=%b", Inst_Address,
                     if_id_pc, if_id_instr, if_id_valid, halted, fault);
        end
    endtask

    task automatic test_sequential();
        reset = 1'b1;
        tick();  // BOOT edge
        checks++;
        if ({if_id_valid, Inst_Address} !== {1'b0, 64'h0}) begin
            errors++;
            $display("FAIL boot_cycle: v=%b addr=%h expected v=0 addr=0", if_id_valid, Inst_Address);
        end
        tick();
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, Inst_Address} !==
            {32'h009A84B3, 64'h0, 1'b1, 64'h4}) begin
            errors++;
            $display("FAIL seq_fetch0: instr=%h pc=%h v=%b addr=%h", if_id_instr, if_id_pc,
                     if_id_valid, Inst_Address);
        end
        tick();
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, Inst_Address} !==
            {32'h00000013, 64'h4, 1'b1, 64'h8}) begin
            errors++;
            $display("FAIL seq_fetch4: instr=%h pc=%h v=%b addr=%h", if_id_instr, if_id_pc,
                     if_id_valid, Inst_Address);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({Inst_Address, if_id_instr, if_id_pc, if_id_valid} !==
                {64'h8, 32'h00000013, 64'h4, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: addr=%h instr=%h pc=%h v=%b", i, Inst_Address,
                         if_id_instr, if_id_pc, if_id_valid);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, Inst_Address} !==
            {32'h00100093, 64'h8, 1'b1, 64'hC}) begin
            errors++;
            $display("FAIL stall_release: instr=%h pc=%h v=%b addr=%h", if_id_instr, if_id_pc,
                     if_id_valid, Inst_Address);
        end
    endtask

    task automatic test_redirect();
        branch_taken  = 1'b1;
        branch_target = 64'h40;
        stall         = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if ({Inst_Address, if_id_valid, if_id_instr, if_id_pc} !==
            {64'h40, 1'b0, 32'h00000013, 64'hC}) begin
            errors++;
            $display("FAIL redirect_bubble: addr=%h v=%b instr=%h pc=%h", Inst_Address,
                     if_id_valid, if_id_instr, if_id_pc);
        end
        tick();
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, Inst_Address} !==
            {32'h00308193, 64'h40, 1'b1, 64'h44}) begin
            errors++;
            $display("FAIL redirect_fetch: instr=%h pc=%h v=%b addr=%h", if_id_instr, if_id_pc,
                     if_id_valid, Inst_Address);
        end
    endtask

    task automatic test_misaligned();
        branch_taken  = 1'b1;
        branch_target = 64'h42;
        tick();
        checks++;
        if ({halted, fault, Inst_Address, if_id_valid, if_id_instr} !==
            {1'b1, 1'b1, 64'h44, 1'b0, 32'h00000013}) begin
            errors++;
            $display("FAIL misaligned_halt: h=%b f=%b addr=%h v=%b instr=%h", halted, fault,
                     Inst_Address, if_id_valid, if_id_instr);
        end
        for (int i = 0; i < 10; i++) begin
            stall         = 1'($urandom_range(0, 1));
            flush         = 1'($urandom_range(0, 1));
            branch_taken  = 1'($urandom_range(0, 1));
            branch_target = 64'($urandom_range(0, 31)) << 2;
            tick();
            checks++;
            if ({halted, fault, Inst_Address, if_id_valid, if_id_instr, if_id_pc} !==
                {1'b1, 1'b1, 64'h44, 1'b0, 32'h00000013, 64'h44}) begin
                errors++;
                $display("FAIL halt_frozen[%0d]: h=%b f=%b addr=%h v=%b instr=%h pc=%h", i,
                         halted, fault, Inst_Address, if_id_valid, if_id_instr, if_id_pc);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        reset         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 64'h80;
        tick();
        checks++;
        if ({Inst_Address, if_id_pc, if_id_instr, if_id_valid, halted, fault} !==
            {64'h0, 64'h0, 32'h00000013, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: addr=%h pc=%h instr=%h v=%b h=%b f=%b", Inst_Address,
                     if_id_pc, if_id_instr, if_id_valid, halted, fault);
        end
        reset = 1'b1;
        clear_inputs();
        tick();  // BOOT
        checks++;
        if ({if_id_valid, Inst_Address} !== {1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset_boot: v=%b addr=%h expected v=0 addr=0", if_id_valid, Inst_Address);
        end
        tick();
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, Inst_Address} !==
            {32'h009A84B3, 64'h0, 1'b1, 64'h4}) begin
            errors++;
            $display("FAIL reset_resume: instr=%h pc=%h v=%b addr=%h", if_id_instr, if_id_pc,
                     if_id_valid, Inst_Address);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        checks++;
        if ({Inst_Address, if_id_valid, if_id_instr, if_id_pc} !==
            {64'h8, 1'b0, 32'h00000013, 64'h4}) begin
            errors++;
            $display("FAIL flush_bubble: addr=%h v=%b instr=%h pc=%h", Inst_Address, if_id_valid,
                     if_id_instr, if_id_pc);
        end
        stall = 1'b1;  // stall wins over flush
        tick();
        checks++;
        if ({Inst_Address, if_id_valid, if_id_pc} !== {64'h8, 1'b0, 64'h4}) begin
            errors++;
            $display("FAIL stall_over_flush: addr=%h v=%b pc=%h", Inst_Address, if_id_valid,
                     if_id_pc);
        end
        clear_inputs();
        tick();
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, Inst_Address} !==
            {32'h00100093, 64'h8, 1'b1, 64'hC}) begin
            errors++;
            $display("FAIL after_flush: instr=%h pc=%h v=%b addr=%h", if_id_instr, if_id_pc,
                     if_id_valid, Inst_Address);
        end
    endtask

    task automatic test_range_halt();
        branch_taken  = 1'b1;
        branch_target = 64'd124;
        flush         = 1'b1;  // redirect wins over flush
        tick();
        clear_inputs();
        checks++;
        if ({Inst_Address, if_id_valid} !== {64'd124, 1'b0}) begin
            errors++;
            $display("FAIL range_redirect: addr=%h v=%b", Inst_Address, if_id_valid);
        end
        tick();
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, Inst_Address} !==
            {32'h0, 64'd124, 1'b1, 64'd128}) begin
            errors++;
            $display("FAIL range_fetch124: instr=%h pc=%h v=%b addr=%h", if_id_instr, if_id_pc,
                     if_id_valid, Inst_Address);
        end
        tick();
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, Inst_Address, halted} !==
            {32'h00400213, 64'd128, 1'b1, 64'd132, 1'b0}) begin
            errors++;
            $display("FAIL range_fetch128: instr=%h pc=%h v=%b addr=%h h=%b", if_id_instr,
                     if_id_pc, if_id_valid, Inst_Address, halted);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({halted, fault, if_id_valid, if_id_instr, Inst_Address} !==
                {1'b1, 1'b0, 1'b0, 32'h00000013, 64'd132}) begin
                errors++;
                $display("FAIL range_halt[%0d]: h=%b f=%b v=%b instr=%h addr=%h", i, halted,
                         fault, if_id_valid, if_id_instr, Inst_Address);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        put_word(0, 32'h009A84B3);
        put_word(4, 32'h00000013);
        put_word(8, 32'h00100093);
        put_word(12, 32'h00200113);
        put_word(64, 32'h00308193);
        put_word(128, 32'h00400213);

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_reset_mid();
        test_flush();
        test_range_halt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the byte-addressed, combinational instruction memory (64-bit Inst_Address in, 32-bit little-endian Instruction out) for the pipelined RISC-V core.
- Owns the PC register and drives Inst_Address.
- Captures each fetched word into the IF/ID pipeline register.
- Applies hazard-unit stalls, EX-stage branch redirects and flushes, and halts fetch on out-of-range or misaligned PCs.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- MEM_BYTES, 132, size of the instruction memory in bytes; legal fetch requires PC+3 < MEM_BYTES.
- NOP_INSTR, 32'h00000013, bubble word (addi x0,x0,0) inserted on flush, redirect or halt.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hazard-unit stall: hold PC and IF/ID.
- flush  in  1  squash the word being fetched this cycle.
- branch_taken  in  1  EX-stage redirect request.
- branch_target  in  64  redirect PC.
- Instruction  in  32  word returned by instruction memory for Inst_Address.
- Inst_Address  out  64  current PC; to instruction memory.
- if_id_pc  out  64  PC of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped (sticky until reset).
- fault  out  1  halt cause was a misaligned redirect (sticky until reset).

Behaviour:
- Reset (reset==0 at posedge):
  - PC=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, halted=0, fault=0.
  - State=BOOT.
  - Reset overrides every other input, including mid-stall and mid-redirect.
- Inst_Address = PC, combinationally. Memory read latency is zero; Instruction is sampled on the same edge that advances the PC.
- FSM states: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after reset deasserts.
  - PC held, IF/ID holds bubble.
  - Unconditional transition to RUN, unless the RESET_PC range check fails; then go to HALT.
- RUN, priority per edge, highest first:
  1. branch_taken:
     - If branch_target[1:0]!=0: go to HALT, fault=1, PC unchanged.
     - Otherwise PC=branch_target.
     - In both cases IF/ID is loaded with bubble (valid=0, instr=NOP_INSTR, pc=old PC).
     - A redirect overrides stall.
  2. stall: PC and IF/ID hold their values exactly.
  3. flush: PC=PC+4; IF/ID gets bubble (valid=0, pc=old PC).
  4. Normal: if_id_pc=PC, if_id_instr=Instruction, if_id_valid=1, PC=PC+4.
- Range check:
  - Evaluated before every non-stalled fetch, including the first fetch after a redirect.
  - If PC+3 >= MEM_BYTES: no capture, IF/ID gets bubble, go to HALT, halted=1, fault=0.
  - A redirect to an out-of-range aligned target is accepted; the next non-stalled cycle then halts.
- HALT:
  - PC frozen; IF/ID loaded with bubble on the first HALT edge, then held.
  - Inputs are ignored; only reset exits HALT.
  - halted=1 in HALT; fault is set only via the misaligned path.
- Arithmetic:
  - PC+4 is 64-bit unsigned and wraps modulo 2^64.
  - The range check is computed in 65 bits so wrap cannot pass it.
- Simultaneous events: branch_taken + flush act as branch_taken; stall + flush act as stall (the flush is dropped; the hazard unit re-asserts it if needed).
- No combinational path from inputs to IF/ID outputs; Inst_Address depends only on the PC register.

Decomposition:
- Shared package rv_fetch_pkg:
  - FSM state enum (BOOT, RUN, HALT).
  - NOP_INSTR constant.
  - 64-bit pc_t typedef.
  - IF/ID struct {pc, instr, valid}.
- One natural sub-module: if_id_reg. It is the IF/ID pipeline register with hold (stall) and bubble-load controls. It is reused later by the decode-stage owner.
- The PC/FSM logic stays in fetch_sequencer.

Test Plan:
1. Sequential fetch:
   - Setup: memory bytes 0..3 = B3 84 9A 00, bytes 4..7 = 13 00 00 00, release reset.
   - Required: BOOT cycle with valid=0.
   - Then if_id_instr=32'h009A84B3, pc=0, valid=1.
   - Next cycle: 32'h00000013, pc=4.
   - Inst_Address steps 0,4,8.
2. Stall:
   - Stimulus: assert stall for 3 cycles at PC=8.
   - Required: Inst_Address stays 8 and IF/ID is unchanged for 3 cycles; on release it fetches from 8 with no skipped or duplicated instruction.
3. Redirect:
   - Stimulus: branch_taken=1, branch_target=64'h40 while stall=1 at PC=12.
   - Required: next PC=0x40, IF/ID bubble (valid=0, instr=0x00000013).
   - The following cycle captures memory[0x40..0x43] with pc=0x40.
4. Misaligned redirect:
   - Stimulus: branch_target=64'h42.
   - Required: halted=1, fault=1, PC unchanged, valid=0.
   - Outputs stay constant for 10 cycles despite toggled inputs.
5. Range halt:
   - Stimulus: run with MEM_BYTES=132 to PC=128, then continue.
   - Required: word at 128 is captured.
   - The fetch at PC=132 halts instead: halted=1, fault=0, valid=0.
6. Reset mid-operation:
   - Stimulus: reset=0 for one edge while branch_taken=1 and in HALT.
   - Required: PC=RESET_PC, all outputs at reset values, BOOT then RUN resumes fetching from 0.
